pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 core. It generates stall and bubble controls for the F/D/E/M/W pipeline registers: load/use, ret, branch mispredict and exception handling. It also tracks processor status with a small RUN/DRAIN/HALTED state machine and can optionally count hazard events. It sits beside the pipeline registers, and its outputs drive their stall and bubble inputs directly.

Parameters:
CNT_W, 32, width of each performance counter (used only with PERF_CNT_EN)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
D_icode  input  4  icode in decode stage
d_srcA  input  4  decode source A register (4'hF = none)
d_srcB  input  4  decode source B register (4'hF = none)
E_icode  input  4  icode in execute stage
E_dstM  input  4  execute-stage memory destination register
e_Cnd  input  1  branch condition computed in execute
M_icode  input  4  icode in memory stage
m_stat  input  3  status leaving memory stage
W_stat  input  3  status in writeback stage
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold D register
D_bubble  output  1  load nop into D register
E_bubble  output  1  load nop into E register
M_bubble  output  1  load nop into M register
W_stall  output  1  hold W register
cpu_stat  output  3  architectural status (1 AOK, 2 HLT, 3 ADR, 4 INS)
halted  output  1  high in HALTED state
cyc_cnt, lu_cnt, mp_cnt, ret_cnt  output  CNT_W each  counters; present only with PERF_CNT_EN

Behaviour:
- Encodings: IJXX=7, IMRMOVQ=5, IRET=9, IPOPQ=B. A status is an exception when it is not AOK (1).
- load_use = (E_icode==5 or E_icode==B) and E_dstM!=F and (E_dstM==d_srcA or E_dstM==d_srcB).
- mispred = E_icode==7 and !e_Cnd.
- ret_in = IRET in any of D_icode, E_icode, M_icode.
- exc_m = m_stat is an exception. exc_w = W_stat is an exception.
- All control outputs are combinational from the inputs and state (zero-cycle latency).
- In RUN and DRAIN:
  - F_stall = load_use or ret_in.
  - D_stall = load_use.
  - D_bubble = mispred or (ret_in and !load_use).
  - E_bubble = mispred or load_use.
  - M_bubble = exc_m or exc_w.
  - W_stall = exc_w.
- D_stall and D_bubble are never both high. A load/use hazard takes priority over ret.
- State machine, 2-bit register, async reset to RUN:
  - RUN -> DRAIN when exc_m and !exc_w.
  - RUN -> HALTED when exc_w; cpu_stat <= W_stat in the same edge.
  - DRAIN -> HALTED when exc_w; cpu_stat <= W_stat.
  - DRAIN -> RUN if exc_m drops without exc_w. This does not occur architecturally, but it must be handled.
  - HALTED is sticky until rst_n is asserted.
- In HALTED: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1, M_bubble=1, W_stall=1, halted=1.
- Reset values: state RUN, cpu_stat=3'd1, halted=0, all counters 0. While in reset the control outputs follow the RUN equations.
- If exc_w and exc_m are high together, W takes priority: go to HALTED and latch W_stat.
- Reset mid-operation clears state and cpu_stat immediately (asynchronous). The first rising edge after deassertion is a normal RUN cycle.

Optional Feature:
PERF_CNT_EN:
- When defined: four CNT_W-bit counters are instantiated and exported.
  - cyc_cnt increments every clock not in HALTED.
  - lu_cnt increments on cycles with load_use.
  - mp_cnt increments on cycles with mispred.
  - ret_cnt increments on the first cycle of each ret sequence: ret_in high and D_icode==9 and the previous cycle did not have D_icode==9 with D_stall low.
  - All counters saturate at all-ones, freeze in HALTED, and clear on reset.
- When undefined: counter ports and logic are absent; control behaviour is identical.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 for exactly that cycle; with E_dstM=F -> all 0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 -> all 0.
- Ret sequence: IRET steps through D, E, M over 3 cycles -> F_stall=1 and D_bubble=1 each cycle, both 0 on the 4th cycle. IRET in D together with load_use -> D_stall=1, D_bubble=0.
- Halt: m_stat=2 for one cycle, then W_stat=2 -> M_bubble=1 in both cycles, state RUN->DRAIN->HALTED, cpu_stat=2, halted=1, all stalls held for 10 further cycles.
- Simultaneous exceptions: m_stat=4 and W_stat=3 in the same cycle -> HALTED with cpu_stat=3. Assert rst_n=0 mid-cycle -> cpu_stat=1, halted=0 immediately.
- PERF_CNT_EN: 5 load/use cycles, 2 mispredicts, 1 ret, then halt -> lu_cnt=5, mp_cnt=2, ret_cnt=1, cyc_cnt frozen after halt. With CNT_W=4, 20 run cycles -> cyc_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard control: stall/bubble generation plus RUN/DRAIN/HALTED status FSM.
// Latency: control outputs are combinational (0 cycles); cpu_stat/halted update on the clock edge.
// Backpressure: none; outputs drive the pipeline-register stall/bubble inputs directly.
// Optional hazard counters are compiled in when the PERF_CNT_EN macro is defined.
module pipe_hazard_ctrl
`ifdef PERF_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic [2:0] cpu_stat,
  output logic       halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] cpu_stat_q;
  logic       halted_q;

  logic load_use;
  logic mispred;
  logic ret_in;
  logic exc_m;
  logic exc_w;
  logic in_halt;

  assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred  = (E_icode == IJXX) && !e_Cnd;
  assign ret_in   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign exc_m    = (m_stat != SAOK);
  assign exc_w    = (W_stat != SAOK);
  assign in_halt  = (state_q == ST_HALTED);

  // Pipeline register controls; load/use wins over ret so D is held rather than bubbled.
  always_comb begin
    F_stall  = load_use || ret_in;
    D_stall  = load_use;
    D_bubble = mispred || (ret_in && !load_use);
    E_bubble = mispred || load_use;
    M_bubble = exc_m || exc_w;
    W_stall  = exc_w;
    if (in_halt) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end
  end

  // Status FSM; a writeback exception always wins and latches its status code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= SAOK;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_w) begin
            state_q    <= ST_HALTED;
            cpu_stat_q <= W_stat;
            halted_q   <= 1'b1;
          end else if (exc_m) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (exc_w) begin
            state_q    <= ST_HALTED;
            cpu_stat_q <= W_stat;
            halted_q   <= 1'b1;
          end else if (!exc_m) begin
            // Exception vanished from M without reaching W; resume normally.
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          cpu_stat_q <= SAOK;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign halted   = halted_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q;
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;
  logic [CNT_W-1:0] ret_cnt_q;
  logic             prev_dret_q;
  logic             ret_start;

  // A ret sequence starts when IRET enters D without having already advanced out of D last cycle.
  assign ret_start = ret_in && (D_icode == IRET) && !prev_dret_q;

  // Saturating event counters, frozen while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      lu_cnt_q    <= '0;
      mp_cnt_q    <= '0;
      ret_cnt_q   <= '0;
      prev_dret_q <= 1'b0;
    end else begin
      prev_dret_q <= (D_icode == IRET) && !D_stall;
      if (!in_halt) begin
        if (cyc_cnt_q != '1)              cyc_cnt_q <= cyc_cnt_q + 1'b1;
        if (load_use && lu_cnt_q != '1)   lu_cnt_q  <= lu_cnt_q + 1'b1;
        if (mispred && mp_cnt_q != '1)    mp_cnt_q  <= mp_cnt_q + 1'b1;
        if (ret_start && ret_cnt_q != '1) ret_cnt_q <= ret_cnt_q + 1'b1;
      end
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic compared against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0] cpu_stat;

  int checks = 0;
  int errors = 0;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;
  logic [3:0]  cyc4, lu4, mp4, ret4;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .cpu_stat(cpu_stat), .halted(halted)
`ifdef PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
`endif
  );

`ifdef PERF_CNT_EN
  logic F4, D4, Db4, Eb4, Mb4, W4, h4;
  logic [2:0] cs4;
  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F4), .D_stall(D4), .D_bubble(Db4),
    .E_bubble(Eb4), .M_bubble(Mb4), .W_stall(W4),
    .cpu_stat(cs4), .halted(h4),
    .cyc_cnt(cyc4), .lu_cnt(lu4), .mp_cnt(mp4), .ret_cnt(ret4)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: 0 running, 1 draining, 2 halted.
  int          md_st;
  logic [2:0]  md_cpu;
  longint      md_cyc, md_lu, md_mp, md_ret;
  bit          md_prev_dret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic model_reset();
    md_st = 0; md_cpu = 3'd1;
    md_cyc = 0; md_lu = 0; md_mp = 0; md_ret = 0; md_prev_dret = 0;
  endtask

  // One clock: inputs already applied just after a negedge. Check, clock, update model.
  task automatic cyc();
    bit lu, mp, rt, em, ew;
    logic [5:0] e;
    #1;
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    mp = (E_icode == 4'd7) && !e_Cnd;
    rt = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    em = (m_stat != 3'd1);
    ew = (W_stat != 3'd1);
    if (md_st == 2) e = 6'b110111;
    else e = {lu | rt, lu, mp | (rt & !lu), mp | lu, em | ew, ew};
    chk("ctrl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, e);
    chk("halted", halted, (md_st == 2));
    chk("cpu_stat", cpu_stat, md_cpu);
`ifdef PERF_CNT_EN
    chk("cyc_cnt", cyc_cnt, md_cyc);
    chk("lu_cnt", lu_cnt, md_lu);
    chk("mp_cnt", mp_cnt, md_mp);
    chk("ret_cnt", ret_cnt, md_ret);
`endif
    @(posedge clk);
    if (md_st != 2) begin
      md_cyc++;
      if (lu) md_lu++;
      if (mp) md_mp++;
      if (rt && D_icode == 4'd9 && !md_prev_dret) md_ret++;
      if (ew) begin md_st = 2; md_cpu = W_stat; end
      else if (md_st == 0 && em) md_st = 1;
      else if (md_st == 1 && !em) md_st = 0;
    end
    md_prev_dret = (D_icode == 4'd9) && !e[4];
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_cpu_stat", cpu_stat, 3'd1);
    chk("rst_halted", halted, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] d, sa, sb, e, dm, m;
    logic       cnd;
    logic [5:0] exp; // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  } vec_t;

  vec_t tbl[10];
  longint cyc_hold;

  initial begin
    tbl[0] = '{d:4'h1, sa:4'h3, sb:4'hF, e:4'h5, dm:4'h3, m:4'h1, cnd:1'b1, exp:6'b110100};
    tbl[1] = '{d:4'h1, sa:4'h3, sb:4'hF, e:4'h5, dm:4'hF, m:4'h1, cnd:1'b1, exp:6'b000000};
    tbl[2] = '{d:4'h1, sa:4'hF, sb:4'h4, e:4'hB, dm:4'h4, m:4'h1, cnd:1'b1, exp:6'b110100};
    tbl[3] = '{d:4'h1, sa:4'h3, sb:4'hF, e:4'h6, dm:4'h3, m:4'h1, cnd:1'b1, exp:6'b000000};
    tbl[4] = '{d:4'h1, sa:4'hF, sb:4'hF, e:4'h7, dm:4'hF, m:4'h1, cnd:1'b0, exp:6'b001100};
    tbl[5] = '{d:4'h1, sa:4'hF, sb:4'hF, e:4'h7, dm:4'hF, m:4'h1, cnd:1'b1, exp:6'b000000};
    tbl[6] = '{d:4'h9, sa:4'hF, sb:4'hF, e:4'h1, dm:4'hF, m:4'h1, cnd:1'b1, exp:6'b101000};
    tbl[7] = '{d:4'h1, sa:4'hF, sb:4'hF, e:4'h1, dm:4'hF, m:4'h9, cnd:1'b1, exp:6'b101000};
    tbl[8] = '{d:4'h9, sa:4'h2, sb:4'hF, e:4'h5, dm:4'h2, m:4'h1, cnd:1'b1, exp:6'b110100};
    tbl[9] = '{d:4'h9, sa:4'hF, sb:4'hF, e:4'h7, dm:4'hF, m:4'h1, cnd:1'b0, exp:6'b101100};

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cpu_stat", cpu_stat, 3'd1);
    chk("reset_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 20 idle run cycles: exercises the narrow counter's saturation.
    repeat (20) cyc();
`ifdef PERF_CNT_EN
    chk("cyc4_sat", cyc4, 4'd15);
    chk("cyc32_20", cyc_cnt, 32'd20);
`endif

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      D_icode = tbl[i].d; d_srcA = tbl[i].sa; d_srcB = tbl[i].sb;
      E_icode = tbl[i].e; E_dstM = tbl[i].dm; M_icode = tbl[i].m; e_Cnd = tbl[i].cnd;
      #1;
      chk($sformatf("vec%0d", i), {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, tbl[i].exp);
      #1;
      cyc();
    end

    // Ret walking D -> E -> M, then clear on the fourth cycle.
    mid_reset();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) D_icode = 4'h9;
      if (i == 1) E_icode = 4'h9;
      if (i == 2) M_icode = 4'h9;
      #1;
      chk($sformatf("ret_F_stall%0d", i), F_stall, (i < 3));
      chk($sformatf("ret_D_bubble%0d", i), D_bubble, (i < 3));
      #1;
      cyc();
    end

    // Perf scenario: 5 load/use, 2 mispredicts, 1 ret, then halt.
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; cyc();
    end
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); E_icode = 4'h7; e_Cnd = 1'b0; cyc();
    end
    idle_inputs(); D_icode = 4'h9; cyc();
    idle_inputs(); E_icode = 4'h9; cyc();
    idle_inputs(); M_icode = 4'h9; cyc();

    // Halt: exception in M, then in W.
    idle_inputs(); m_stat = 3'd2;
    #1 chk("halt_mb_m", M_bubble, 1'b1); #1;
    cyc();
    chk("drain_not_halted", halted, 1'b0);
    idle_inputs(); W_stat = 3'd2;
    #1 chk("halt_mb_w", M_bubble, 1'b1); chk("halt_wstall", W_stall, 1'b1); #1;
    cyc();
    chk("halt_cpu_stat", cpu_stat, 3'd2);
    chk("halt_halted", halted, 1'b1);
    cyc_hold = md_cyc;
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      D_icode = 4'($urandom_range(0, 11)); E_icode = 4'($urandom_range(0, 11));
      E_dstM = 4'($urandom_range(0, 15)); d_srcA = 4'($urandom_range(0, 15));
      #1 chk($sformatf("halt_hold%0d", i),
             {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b110111); #1;
      cyc();
    end
`ifdef PERF_CNT_EN
    chk("perf_lu", lu_cnt, 32'd5);
    chk("perf_mp", mp_cnt, 32'd2);
    chk("perf_ret", ret_cnt, 32'd1);
    chk("perf_cyc_frozen", cyc_cnt, cyc_hold);
`endif

    // Simultaneous M and W exceptions: W status wins.
    mid_reset();
    idle_inputs(); m_stat = 3'd4; W_stat = 3'd3; cyc();
    chk("simul_cpu_stat", cpu_stat, 3'd3);
    chk("simul_halted", halted, 1'b1);
    idle_inputs(); cyc();
    mid_reset();

    // Drain that recovers without reaching W.
    idle_inputs(); m_stat = 3'd3; cyc();
    idle_inputs(); cyc();
    idle_inputs(); m_stat = 3'd2; cyc();
    chk("recover_not_halted", halted, 1'b0);
    idle_inputs(); cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      D_icode = 4'($urandom_range(0, 11));
      E_icode = ($urandom_range(0, 2) == 0) ? 4'h5 : 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      d_srcA  = 4'($urandom_range(0, 15));
      d_srcB  = 4'($urandom_range(0, 15));
      E_dstM  = ($urandom_range(0, 1) == 0) ? d_srcA : 4'($urandom_range(0, 15));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      cyc();
      if (md_st == 2 && $urandom_range(0, 3) == 0) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
